seg7_multi_scan: RTL and testbench

SEG7_MULTI_SCAN -- requirements
Module: seg7_multi_scan

---
 rtl/seg7_multi_scan.sv | 241 ++++++++++++++++++++++++
 tb/tb_seg7_multi_scan.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_multi_scan.sv
// ---------------------------------------------------------------------------
// seg7_multi_scan
//
// Time-multiplexed driver for a row of common-anode/cathode seven-segment
// hex digits. A prescaler divides the clock into digit slots. Each slot
// drives one anode and shows that digit's segment pattern. The first few
// cycles of every slot keep all anodes dark so that ghosting from the
// previous digit cannot appear.
//
// Display content comes only from shadow registers, which are captured
// on a one-cycle load strobe. Because of this the source can update its
// data at any time without tearing a digit that is on screen.
//
// Features: optional leading-zero blanking, a per-digit decimal point,
// a per-digit blink driven by a slot-counted phase, and selectable output
// polarity.
//
// Parameters
//   NUM_DIGITS : number of hex digits driven (2..16)
//   SCAN_DIV   : clock cycles per digit slot (>= 4)
//   DEAD_CYC   : leading cycles of each slot with all anodes off
//   BLINK_DIV  : digit slots per blink half-period (>= 1)
//   ACTIVE_LOW : 1 = anodes/segments active-low, 0 = active-high
//
// Ports
//   clock       : single clock
//   reset       : synchronous, active-high reset
//   data        : 4*NUM_DIGITS bits, nibble k drives digit k (digit 0 rightmost)
//   dp_mask     : decimal-point enable per digit
//   blink_mask  : blink enable per digit
//   blank_lz    : leading-zero blanking enable
//   load        : one-cycle strobe capturing data/dp_mask/blink_mask/blank_lz
//   an          : registered one-hot anode select
//   seg_code    : registered segment code, bit 7 = dp, bits 6..0 = g..a
//   frame_start : one-cycle pulse when the digit-0 slot begins
// ---------------------------------------------------------------------------
module seg7_multi_scan #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int DEAD_CYC   = 2,
    parameter int BLINK_DIV  = 64,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blank_lz,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg_code,
    output logic                    frame_start
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] DEAD_END   = PW'(DEAD_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    // Electrical level meaning "off" on the pins. XOR-ing an active-high
    // pattern with this level gives the pin value for either polarity.
    localparam logic OFF_LVL = (ACTIVE_LOW != 0);

    typedef enum logic {
        BLINK_SHOW = 1'b0,
        BLINK_HIDE = 1'b1
    } blink_phase_t;

    // Shadow copies of the display content
    logic [4*NUM_DIGITS-1:0] sh_data;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blink;
    logic                    sh_blank_lz;

    // Scan and blink timing state
    logic [PW-1:0]  presc;
    logic [IW-1:0]  idx;
    logic [BW-1:0]  blink_cnt;
    blink_phase_t   blink_phase;
    logic           slot_tick;
    logic           in_dead;

    // Decoded content for the digit currently indexed
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic                  cur_blink;
    logic                  cur_lz_blank;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [NUM_DIGITS-1:0] an_next;
    logic [7:0]            seg_next;

    // Active-high hex-to-segment map, bit order g..a
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    assign slot_tick = (presc == PRESC_LAST);
    assign in_dead   = (presc < DEAD_END);

    // Capture the source's content on load. Display logic reads only these
    // copies. A load that coincides with a slot tick is captured on the same
    // edge that starts the new slot, so the new slot already shows fresh data.
    always_ff @(posedge clock) begin
        if (reset) begin
            sh_data     <= '0;
            sh_dp       <= '0;
            sh_blink    <= '0;
            sh_blank_lz <= 1'b0;
        end else if (load) begin
            sh_data     <= data;
            sh_dp       <= dp_mask;
            sh_blink    <= blink_mask;
            sh_blank_lz <= blank_lz;
        end
    end

    // Prescaler and digit index. The index steps once per slot and wraps
    // after the last digit. frame_start is raised for the first cycle of
    // the digit-0 slot, which is the cycle right after the wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc       <= '0;
            idx         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= slot_tick && (idx == IDX_LAST);
            if (slot_tick) begin
                presc <= '0;
                if (idx == IDX_LAST) begin
                    idx <= '0;
                end else begin
                    idx <= idx + IW'(1);
                end
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Blink phase counts slots rather than cycles. This keeps the blink rate
    // tied to the scan rate whatever SCAN_DIV is.
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= BLINK_SHOW;
        end else if (slot_tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= (blink_phase == BLINK_SHOW) ? BLINK_HIDE : BLINK_SHOW;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // Leading-zero map. Walk from the most significant digit downward while
    // every nibble seen so far is zero. Digit 0 is always shown so that a
    // value of zero still displays "0".
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_blank = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run    = zero_run && (sh_data[4*k +: 4] == 4'h0);
            lz_blank[k] = sh_blank_lz && zero_run && (k != 0);
        end
    end

    // Pick out the shadow content for the digit being scanned
    always_comb begin
        cur_nibble   = 4'h0;
        cur_dp       = 1'b0;
        cur_blink    = 1'b0;
        cur_lz_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nibble   = sh_data[4*k +: 4];
                cur_dp       = sh_dp[k];
                cur_blink    = sh_blink[k];
                cur_lz_blank = lz_blank[k];
            end
        end
    end

    // Active-high anode and segment pattern for the current cycle. A digit
    // hidden by blink keeps its anode on, so the scan duty of the other
    // digits does not change. Only its segments and dp go dark.
    // Leading-zero blanking clears the segments but leaves the dp alone.
    always_comb begin
        logic blink_off;
        blink_off = cur_blink && (blink_phase == BLINK_HIDE);
        an_next   = '0;
        seg_next  = 8'h00;
        if (!in_dead) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                an_next[k] = (idx == IW'(k));
            end
            seg_next[7] = cur_dp && !blink_off;
            if (!blink_off && !cur_lz_blank) begin
                seg_next[6:0] = hex_to_seg(cur_nibble);
            end
        end
    end

    // Register the pins and apply the output polarity. During reset every
    // pin sits at its inactive level.
    always_ff @(posedge clock) begin
        if (reset) begin
            an       <= {NUM_DIGITS{OFF_LVL}};
            seg_code <= {8{OFF_LVL}};
        end else begin
            an       <= an_next ^ {NUM_DIGITS{OFF_LVL}};
            seg_code <= seg_next ^ {8{OFF_LVL}};
        end
    end

endmodule

// File: tb/tb_seg7_multi_scan.sv
// ---------------------------------------------------------------------------
// tb_seg7_multi_scan
//
// Drives two seg7_multi_scan instances with identical inputs. The two
// instances differ only in output polarity: 4 digits, 8-cycle slots,
// 2 dead cycles and a blink half-period of 2 slots.
//
// Table vectors load a display value, then watch one full frame. The
// expected pin values are pushed to a queue when the load is issued and
// popped cycle by cycle as the frame runs.
//
// Hand-written sequences cover three cases:
//   - the reset state,
//   - a load landing on the slot tick,
//   - a reset that arrives mid-frame.
// ---------------------------------------------------------------------------
module tb_seg7_multi_scan;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int DC = 2;
    localparam int BD = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] data;
    logic [3:0]  dp_mask;
    logic [3:0]  blink_mask;
    logic        blank_lz;
    logic        load;

    logic [3:0]  an0, an1;
    logic [7:0]  seg0, seg1;
    logic        fs0, fs1;

    int n_checks = 0;
    int n_fails  = 0;

    // Table record: the load values, plus the expected active-high segment
    // byte for each digit, packed as {d3, d2, d1, d0}.
    typedef struct {
        string       name;
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blink;
        logic        blz;
        logic [31:0] segs;
    } vec_t;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fs;
    } exp_t;

    vec_t tbl [10];
    exp_t exp_q [$];

    seg7_multi_scan #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_DIV(BD), .ACTIVE_LOW(0)
    ) dut_hi (
        .clock(clock), .reset(reset), .data(data), .dp_mask(dp_mask),
        .blink_mask(blink_mask), .blank_lz(blank_lz), .load(load),
        .an(an0), .seg_code(seg0), .frame_start(fs0)
    );

    seg7_multi_scan #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_DIV(BD), .ACTIVE_LOW(1)
    ) dut_lo (
        .clock(clock), .reset(reset), .data(data), .dp_mask(dp_mask),
        .blink_mask(blink_mask), .blank_lz(blank_lz), .load(load),
        .an(an1), .seg_code(seg1), .frame_start(fs1)
    );

    // 10 ns clock
    always #5 clock = ~clock;

    // Hard stop in case something wedges the stimulus thread
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison: counts it, and reports a failure when got != want
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // One-cycle load strobe, driven away from the active edge
    task automatic loadRegs(input logic [15:0] d, input logic [3:0] dp,
                            input logic [3:0] bl, input logic blz);
        @(negedge clock);
        data       = d;
        dp_mask    = dp;
        blink_mask = bl;
        blank_lz   = blz;
        load       = 1'b1;
        @(negedge clock);
        load       = 1'b0;
    endtask

    // Load a table vector and queue the pin values for the next full frame.
    // The frame covers 4 slots of 8 cycles: 2 dead cycles, then 6 active.
    // The last entry of the frame coincides with the next frame_start pulse.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        loadRegs(v.data, v.dp, v.blink, v.blz);
        for (int s = 0; s < ND; s++) begin
            for (int j = 0; j < SD; j++) begin
                e.an  = (j < DC) ? 4'b0000 : 4'(1 << s);
                e.seg = (j < DC) ? 8'h00 : v.segs[8*s +: 8];
                e.fs  = (s == ND - 1) && (j == SD - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Wait, with a bound, for a frame_start pulse sampled on the falling edge
    task automatic waitFrame(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            if (fs0 === 1'b1) seen = 1'b1;
        end
        checkOutput({name, ".frame_start_seen"}, {31'd0, seen}, 32'd1);
    endtask

    // Align to the frame, then compare both polarities each cycle
    // against the queued expectations
    task automatic checkFrame(input string name);
        exp_t e;
        int   k;
        waitFrame(name);
        k = 0;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            e = exp_q.pop_front();
            checkOutput($sformatf("%s.hi.s%0d.c%0d", name, k / SD, k % SD),
                        {19'd0, an0, seg0, fs0}, {19'd0, e.an, e.seg, e.fs});
            checkOutput($sformatf("%s.lo.s%0d.c%0d", name, k / SD, k % SD),
                        {19'd0, an1, seg1, fs1}, {19'd0, ~e.an, ~e.seg, e.fs});
            k++;
        end
    endtask

    initial begin
        // Blink phase is 0 in slots 0-1 and 1 in slots 2-3 of every frame,
        // because a 4-slot frame equals one full 2+2 slot blink period.
        tbl[0] = '{"scan_0123", 16'h0123, 4'b0000, 4'b0000, 1'b0, 32'h3F065B4F};
        tbl[1] = '{"hex_1234",  16'h1234, 4'b0000, 4'b0000, 1'b0, 32'h065B4F66};
        tbl[2] = '{"lz_0050",   16'h0050, 4'b0000, 4'b0000, 1'b1, 32'h00006D3F};
        tbl[3] = '{"lz_0000",   16'h0000, 4'b0000, 4'b0000, 1'b1, 32'h0000003F};
        tbl[4] = '{"nolz_0050", 16'h0050, 4'b0000, 4'b0000, 1'b0, 32'h3F3F6D3F};
        tbl[5] = '{"blink_dp",  16'h0000, 4'b0101, 4'b0101, 1'b0, 32'h3F003FBF};
        tbl[6] = '{"abcd_dp",   16'hABCD, 4'b1010, 4'b0000, 1'b1, 32'hF77CB95E};
        tbl[7] = '{"hex_89ef",  16'h89EF, 4'b0000, 4'b0000, 1'b0, 32'h7F6F7971};
        tbl[8] = '{"lz_dp_top", 16'h0100, 4'b1000, 4'b0000, 1'b1, 32'h80063F3F};
        tbl[9] = '{"blink_hi",  16'h5670, 4'b0100, 4'b1100, 1'b0, 32'h0000073F};

        reset      = 1'b1;
        data       = 16'h0000;
        dp_mask    = 4'b0000;
        blink_mask = 4'b0000;
        blank_lz   = 1'b0;
        load       = 1'b0;

        // Reset state: all pins inactive and no frame pulse
        repeat (3) @(negedge clock);
        checkOutput("reset.hi", {19'd0, an0, seg0, fs0}, {19'd0, 4'h0, 8'h00, 1'b0});
        checkOutput("reset.lo", {19'd0, an1, seg1, fs1}, {19'd0, 4'hF, 8'hFF, 1'b0});
        reset = 1'b0;

        $display("[TB] running %0d table vectors", 10);
        for (int t = 0; t < 10; t++) begin
            applyStimulus(tbl[t]);
            checkFrame(tbl[t].name);
        end

        // Load landing on the slot tick: slot 0 ends on old data, and
        // slot 1 opens with the new value
        $display("[TB] sequence: load on slot tick");
        loadRegs(16'h0000, 4'b0000, 4'b0000, 1'b0);
        waitFrame("tick_load");
        repeat (7) @(negedge clock);
        data = 16'hFFFF;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        checkOutput("tick_load.old", {20'd0, an0, seg0}, {20'd0, 4'b0001, 8'h3F});
        @(negedge clock);
        checkOutput("tick_load.dead", {20'd0, an0, seg0}, {20'd0, 4'b0000, 8'h00});
        repeat (2) @(negedge clock);
        checkOutput("tick_load.new", {20'd0, an0, seg0}, {20'd0, 4'b0010, 8'h71});
        checkOutput("tick_load.new_lo", {20'd0, an1, seg1}, {20'd0, 4'b1101, 8'h8E});

        // Reset during the digit-2 slot, with a competing load that must
        // be ignored. Scanning then restarts at digit 0 with cleared shadows.
        $display("[TB] sequence: mid-frame reset");
        loadRegs(16'h0123, 4'b0000, 4'b0000, 1'b0);
        waitFrame("mid_reset");
        repeat (20) @(negedge clock);
        checkOutput("mid_reset.before", {20'd0, an0, seg0}, {20'd0, 4'b0100, 8'h06});
        reset = 1'b1;
        data  = 16'h8888;
        load  = 1'b1;
        @(negedge clock);
        load  = 1'b0;
        checkOutput("mid_reset.hi", {19'd0, an0, seg0, fs0}, {19'd0, 4'h0, 8'h00, 1'b0});
        checkOutput("mid_reset.lo", {19'd0, an1, seg1, fs1}, {19'd0, 4'hF, 8'hFF, 1'b0});
        @(negedge clock);
        reset = 1'b0;
        checkOutput("mid_reset.hold", {20'd0, an1, seg1}, {20'd0, 4'hF, 8'hFF});
        @(negedge clock);
        checkOutput("mid_reset.dead0", {20'd0, an0, seg0}, {20'd0, 4'b0000, 8'h00});
        @(negedge clock);
        checkOutput("mid_reset.dead1", {20'd0, an0, seg0}, {20'd0, 4'b0000, 8'h00});
        @(negedge clock);
        checkOutput("mid_reset.first", {20'd0, an0, seg0}, {20'd0, 4'b0001, 8'h3F});
        checkOutput("mid_reset.first_lo", {20'd0, an1, seg1}, {20'd0, 4'b1110, 8'hC0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
